// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank write-back slice.
package regbank_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 32;

  // One pending register write: destination index plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Decode a register index into the bank's one-hot write enable.
  function automatic logic [REG_COUNT-1:0] onehot16(input logic [ADDR_W-1:0] addr);
    onehot16 = REG_COUNT'(1) << addr;
  endfunction

endpackage

// File: rtl/regbank_wr_fifo.sv
// Synchronous FIFO of register-write requests; no fall-through, head
// becomes visible the cycle after it is pushed.
module regbank_wr_fifo
  import regbank_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_req_t          wdata,
  output wb_req_t          rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regbank_write_ctrl.sv
// Write-back arbiter in front of the 16x32 register bank: ALU results win
// by default, buffered load returns are forced through after starving.
// Optional build macro REG0_PROTECT_EN suppresses all writes to register 0.
module regbank_write_ctrl
  import regbank_pkg::*;
#(
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [REG_COUNT-1:0] en,
  output logic [DATA_W-1:0]    R,
  output logic                 mem_pending
);

  localparam int unsigned CNT_W    = ((MEM_FIFO_DEPTH > 1) ? $clog2(MEM_FIFO_DEPTH) : 1) + 1;
  localparam int unsigned STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

  wb_req_t             alu_req;
  wb_req_t             mem_req;
  wb_req_t             fifo_head;
  wb_req_t             wr_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [STARVE_W-1:0] starve_cnt;
  logic                forced_mem;
  logic                grant_mem;
  logic                grant_alu;

  assign alu_req     = '{addr: alu_addr, data: alu_data};
  assign mem_req     = '{addr: mem_addr, data: mem_data};
  assign mem_ready   = !rst && !fifo_full;
  assign mem_pending = (fifo_count != '0);
  assign wr_req      = grant_mem ? fifo_head : alu_req;

  regbank_wr_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_valid && mem_ready),
    .pop   (grant_mem),
    .wdata (mem_req),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Arbitration: ALU by default, FIFO head when ALU idle or starved too long.
  always_comb begin
    forced_mem = 1'b0;
    grant_mem  = 1'b0;
    grant_alu  = 1'b0;
    alu_ready  = 1'b0;
    if (!rst) begin
      forced_mem = !fifo_empty && (starve_cnt == STARVE_MAX);
      alu_ready  = !forced_mem;
      grant_mem  = !fifo_empty && (!alu_valid || forced_mem);
      grant_alu  = alu_valid && !grant_mem;
    end
  end

  // Counts cycles the FIFO head loses arbitration, saturating at the force point.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || grant_mem) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Registered bank write port; R holds its value when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      R  <= '0;
    end else if (grant_alu || grant_mem) begin
`ifdef REG0_PROTECT_EN
      if (wr_req.addr == '0) begin
        en <= '0;
      end else begin
        en <= onehot16(wr_req.addr);
        R  <= wr_req.data;
      end
`else
      en <= onehot16(wr_req.addr);
      R  <= wr_req.data;
`endif
    end else begin
      en <= '0;
    end
  end

endmodule
